instr_sequencer: RTL
====================

Name: instr_sequencer

Overview:
- Top-level control sequencer for the microcontroller.
- Alternates an instruction-fetch phase with an execute phase and dispatches each fetched instruction to exactly one execute FSM (ALU, ALUi, load, store, branch) by opcode.
- Waits for the selected FSM's done, counts retired instructions, and traps halt, illegal opcodes, stray done pulses and hung execute units.

Parameters:
- TIMEOUT, 64, maximum cycles allowed in EXEC before a watchdog fault (legal range 2..255).
- NUM_UNITS, 5, number of execute FSMs on the done/enable vectors.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- run  in  1  level; 1 = keep executing, 0 = stop after the current instruction
- clear  in  1  synchronous; leaves HALTED/FAULT to IDLE
- if_done  in  1  fetch FSM has loaded the instruction (1-cycle pulse)
- instruction  in  16  instruction register contents, valid in the if_done cycle
- done_vec  in  NUM_UNITS  done pulses from the execute FSMs
- if_start  out  1  one-cycle fetch start pulse
- if_active  out  1  fetch phase active; holds all execute FSMs in their idle state
- exec_en  out  NUM_UNITS  one-hot execute-unit select
- halted  out  1  HLT instruction retired
- fault  out  1  sticky error flag
- fault_code  out  2  01 illegal opcode, 10 stray done, 11 watchdog timeout
- retired  out  16  retired-instruction count; wraps at 65535 -> 0

Behaviour:
- All outputs are registered; Moore style.
- Reset values:
  - state IDLE
  - if_active=1
  - if_start=0, exec_en=0, halted=0, fault=0, fault_code=00, retired=0
  - internal ir=0, wdog=0
- States: IDLE, FETCH, DECODE, EXEC, HALTED, FAULT.
- IDLE:
  - if_active=1, exec_en=0.
  - run=1 -> FETCH; if_start=1 for the first FETCH cycle only.
- FETCH:
  - if_active=1.
  - Waits indefinitely for if_done.
  - On if_done, ir <= instruction -> DECODE.
  - Ignores done_vec.
- DECODE (exactly 1 cycle), if_active=1, routes on ir[15:12]:
  - 0000 -> unit0 (ALU)
  - 0001 or 0010 -> unit1 (ALUi)
  - 0011 -> unit2 (load)
  - 0100 -> unit3 (store)
  - 0101 -> unit4 (branch)
  - 1111 -> HALTED (retired+1)
  - any other value -> FAULT, fault_code=01
- EXEC:
  - if_active=0 and exec_en=one-hot of the decoded unit, both held for the whole state.
  - wdog is cleared on entry and increments each cycle.
  - done_vec[unit]=1 -> retired+1. Then run=1 -> FETCH with if_start pulse; run=0 -> IDLE.
  - done from any non-selected unit -> FAULT, fault_code=10. This check has priority over a simultaneous correct done.
  - wdog reaching TIMEOUT-1 without done -> FAULT, fault_code=11.
  - run deasserting mid-EXEC does not abort; the instruction completes.
- HALTED / FAULT:
  - if_active=1, exec_en=0; halted or fault held.
  - clear=1 -> IDLE with halted=0, fault=0, fault_code=00; retired is kept.
  - clear is ignored in every other state.
- Reset mid-operation: all state is lost immediately (asynchronous), exec_en drops at once, and the in-flight instruction is not counted.
- Latency:
  - run rising at cycle 0 -> if_start high in cycle 1.
  - if_done in cycle n -> DECODE in n+1, exec_en valid in n+2.
  - done in cycle m -> if_start in m+1.
- exec_en is never non-zero while if_active=1.

Test Plan:
- ALUi dispatch: run=1, instruction=0x1045, if_done at cycle 3, done_vec=00010 four cycles into EXEC -> exec_en=00010 from cycle 5, retired=1, if_start pulse the cycle after done.
- Back-to-back: opcodes 0000, 0011, 0101 with immediate done -> exec_en sequence 00001, 00100, 10000 and retired=3; run=0 during the third EXEC -> IDLE afterward, no further if_start.
- Halt and illegal: opcode 1111 -> halted=1, retired+1, if_active=1. Opcode 1001 -> fault=1, fault_code=01, retired unchanged. clear -> IDLE with flags cleared.
- Stray done: ALU selected and done_vec=01000 -> fault_code=10. Also drive done_vec=01001 in the same cycle -> still fault_code=10.
- Watchdog: TIMEOUT=8, never assert done -> fault_code=11 exactly 8 cycles after EXEC entry, exec_en=0 next cycle.
- Async reset in EXEC plus counter wrap:
  - rst mid-cycle -> exec_en=0 and if_active=1 without waiting for a clock edge.
  - Separately, preload retired=0xFFFF via 65535 retires, then retire one more -> retired=0x0000.

Source files
------------

// File: rtl/instr_sequencer_if.sv
// ---------------------------------------------------------------------------
// instr_sequencer_if
//   Bundles the control-sequencer handshake and status signals.
//
//   Sequencer inputs : run, clear, if_done, instruction, done_vec
//   Sequencer outputs: if_start, if_active, exec_en, halted, fault,
//                      fault_code, retired
//
//   master modport : the sequencer itself
//   slave  modport : fetch/execute units and status consumers
// ---------------------------------------------------------------------------
interface instr_sequencer_if #(
  parameter int NUM_UNITS = 5
);
  logic                 run;
  logic                 clear;
  logic                 if_done;
  logic [15:0]          instruction;
  logic [NUM_UNITS-1:0] done_vec;

  logic                 if_start;
  logic                 if_active;
  logic [NUM_UNITS-1:0] exec_en;
  logic                 halted;
  logic                 fault;
  logic [1:0]           fault_code;
  logic [15:0]          retired;

  modport master (
    input  run, clear, if_done, instruction, done_vec,
    output if_start, if_active, exec_en, halted, fault, fault_code, retired
  );

  modport slave (
    output run, clear, if_done, instruction, done_vec,
    input  if_start, if_active, exec_en, halted, fault, fault_code, retired
  );
endinterface

// File: rtl/instr_sequencer.sv
// ---------------------------------------------------------------------------
// instr_sequencer
//   Top-level control sequencer. Alternates instruction fetch with execute,
//   dispatches each fetched instruction to one execute FSM by opcode, counts
//   retired instructions and traps halt, illegal opcodes, stray done pulses
//   and hung execute units.
//
//   Parameters
//     TIMEOUT   : cycles allowed in EXEC before the watchdog trips (2..255)
//     NUM_UNITS : width of the done/enable vectors (units 0..4 are used)
//
//   Ports
//     clk  : system clock
//     rst  : asynchronous, active-high reset
//     bus  : instr_sequencer_if master modport
//            in : run, clear, if_done, instruction[15:0], done_vec
//            out: if_start, if_active, exec_en, halted, fault,
//                 fault_code[1:0] (01 illegal, 10 stray done, 11 timeout),
//                 retired[15:0]
// ---------------------------------------------------------------------------
module instr_sequencer #(
  parameter int TIMEOUT   = 64,
  parameter int NUM_UNITS = 5
) (
  input logic                clk,
  input logic                rst,
  instr_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    HALTED,
    FAULT
  } state_t;

  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

  state_t               state;
  logic [15:0]          ir;
  logic [7:0]           wdog;
  logic                 if_start_q;
  logic                 if_active_q;
  logic [NUM_UNITS-1:0] exec_en_q;
  logic                 halted_q;
  logic                 fault_q;
  logic [1:0]           fault_code_q;
  logic [15:0]          retired_q;

  logic [NUM_UNITS-1:0] dec_sel;
  logic                 dec_halt;
  logic                 dec_legal;
  logic                 done_hit;
  logic                 done_stray;

  // Operand fields are consumed by the datapath, not by the sequencer.
  logic                 ir_operand_unused;
  assign ir_operand_unused = ^ir[11:0];

  // Opcode decode of the latched instruction register.
  always_comb begin
    dec_sel   = '0;
    dec_halt  = 1'b0;
    dec_legal = 1'b1;
    case (ir[15:12])
      4'h0:       dec_sel[0] = 1'b1;
      4'h1, 4'h2: dec_sel[1] = 1'b1;
      4'h3:       dec_sel[2] = 1'b1;
      4'h4:       dec_sel[3] = 1'b1;
      4'h5:       dec_sel[4] = 1'b1;
      4'hF:       dec_halt   = 1'b1;
      default:    dec_legal  = 1'b0;
    endcase
  end

  // exec_en_q doubles as the record of which unit owns the current EXEC.
  assign done_hit   = |(bus.done_vec & exec_en_q);
  assign done_stray = |(bus.done_vec & ~exec_en_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      ir           <= '0;
      wdog         <= '0;
      if_start_q   <= 1'b0;
      if_active_q  <= 1'b1;
      exec_en_q    <= '0;
      halted_q     <= 1'b0;
      fault_q      <= 1'b0;
      fault_code_q <= 2'b00;
      retired_q    <= '0;
    end else begin
      if_start_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.run) begin
            state      <= FETCH;
            if_start_q <= 1'b1;
          end
        end

        FETCH: begin
          if (bus.if_done) begin
            ir    <= bus.instruction;
            state <= DECODE;
          end
        end

        DECODE: begin
          if (dec_halt) begin
            state     <= HALTED;
            halted_q  <= 1'b1;
            retired_q <= retired_q + 16'd1;
          end else if (!dec_legal) begin
            state        <= FAULT;
            fault_q      <= 1'b1;
            fault_code_q <= 2'b01;
          end else begin
            state       <= EXEC;
            exec_en_q   <= dec_sel;
            if_active_q <= 1'b0;
            wdog        <= '0;
          end
        end

        // A stray done outranks a correct one; a done in the final
        // watchdog cycle still retires the instruction.
        EXEC: begin
          if (done_stray) begin
            state        <= FAULT;
            fault_q      <= 1'b1;
            fault_code_q <= 2'b10;
            exec_en_q    <= '0;
            if_active_q  <= 1'b1;
          end else if (done_hit) begin
            retired_q   <= retired_q + 16'd1;
            exec_en_q   <= '0;
            if_active_q <= 1'b1;
            if (bus.run) begin
              state      <= FETCH;
              if_start_q <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else if (wdog == WDOG_LAST) begin
            state        <= FAULT;
            fault_q      <= 1'b1;
            fault_code_q <= 2'b11;
            exec_en_q    <= '0;
            if_active_q  <= 1'b1;
          end else begin
            wdog <= wdog + 8'd1;
          end
        end

        HALTED, FAULT: begin
          if (bus.clear) begin
            state        <= IDLE;
            halted_q     <= 1'b0;
            fault_q      <= 1'b0;
            fault_code_q <= 2'b00;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.if_start   = if_start_q;
  assign bus.if_active  = if_active_q;
  assign bus.exec_en    = exec_en_q;
  assign bus.halted     = halted_q;
  assign bus.fault      = fault_q;
  assign bus.fault_code = fault_code_q;
  assign bus.retired    = retired_q;

endmodule
